// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: register enables/flushes, EX forwarding and memory-wait handling.
// Build option: define FWD_EN for EX forwarding with load-use stalls; otherwise full RAW stalls, no forwarding.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_RUN    | normal issue; branch squash and hazard stalls evaluated
// S_MEM_WT | data memory busy; front end frozen, WB bubbled
// S_ERR    | memory timed out; pipeline frozen until reset
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic [4:0]       ex_rs,
   input  logic [4:0]       ex_rt,
   input  logic [4:0]       ex_write_reg,
   input  logic             ex_reg_write,
   input  logic             ex_mem_read,
   input  logic [4:0]       mem_write_reg,
   input  logic             mem_reg_write,
   input  logic [4:0]       wb_write_reg,
   input  logic             wb_reg_write,
   input  logic             ex_branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             mem_wb_flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             mem_timeout_err
);

   typedef enum logic [1:0] {S_RUN, S_MEM_WT, S_ERR} state_t;

   localparam logic [7:0] TIMEOUT_V = 8'(MEM_TIMEOUT);

   state_t     state, state_nxt;
   logic [7:0] wait_cnt, wait_nxt;
   logic       hazard;
   logic [1:0] fwd_a_run, fwd_b_run;

   logic rs_ex, rt_ex;
   assign rs_ex = id_uses_rs && (id_rs == ex_write_reg);
   assign rt_ex = id_uses_rt && (id_rt == ex_write_reg);

`ifdef FWD_EN
   assign hazard = ex_mem_read && ex_reg_write && (ex_write_reg != 5'd0) && (rs_ex || rt_ex);

   always_comb begin
      fwd_a_run = 2'b00;
      fwd_b_run = 2'b00;
      if (mem_reg_write && (mem_write_reg != 5'd0) && (mem_write_reg == ex_rs))
         fwd_a_run = 2'b10;
      else if (wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == ex_rs))
         fwd_a_run = 2'b01;
      if (mem_reg_write && (mem_write_reg != 5'd0) && (mem_write_reg == ex_rt))
         fwd_b_run = 2'b10;
      else if (wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == ex_rt))
         fwd_b_run = 2'b01;
   end
`else
   // Without forwarding, any producer still in EX or MEM blocks the reader in ID.
   logic rs_mem, rt_mem, unused_fwd_inputs;
   assign rs_mem = id_uses_rs && (id_rs == mem_write_reg);
   assign rt_mem = id_uses_rt && (id_rt == mem_write_reg);
   assign hazard = (ex_reg_write && (ex_write_reg != 5'd0) && (rs_ex || rt_ex)) ||
                   (mem_reg_write && (mem_write_reg != 5'd0) && (rs_mem || rt_mem));
   assign fwd_a_run = 2'b00;
   assign fwd_b_run = 2'b00;
   assign unused_fwd_inputs = ^{ex_rs, ex_rt, wb_write_reg, wb_reg_write, ex_mem_read};
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_RUN;
         wait_cnt  <= 8'd0;
         stall_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         if (!pc_en && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      state_nxt       = state;
      wait_nxt        = wait_cnt;
      pc_en           = 1'b1;
      if_id_en        = 1'b1;
      id_ex_en        = 1'b1;
      ex_mem_en       = 1'b1;
      mem_wb_en       = 1'b1;
      if_id_flush     = 1'b0;
      id_ex_flush     = 1'b0;
      mem_wb_flush    = 1'b0;
      fwd_a           = 2'b00;
      fwd_b           = 2'b00;
      mem_timeout_err = 1'b0;

      case (state)
         S_RUN, S_MEM_WT: begin
            if (!dmem_ready && (dmem_req || (state == S_MEM_WT))) begin
               // Freeze everything upstream of MEM; WB takes a bubble so its write is not repeated.
               pc_en        = 1'b0;
               if_id_en     = 1'b0;
               id_ex_en     = 1'b0;
               ex_mem_en    = 1'b0;
               mem_wb_flush = 1'b1;
               if (state == S_RUN) begin
                  state_nxt = S_MEM_WT;
                  wait_nxt  = 8'd1;
               end else if (wait_cnt == TIMEOUT_V) begin
                  state_nxt = S_ERR;
               end else begin
                  wait_nxt = wait_cnt + 8'd1;
               end
            end else begin
               state_nxt = S_RUN;
               fwd_a     = fwd_a_run;
               fwd_b     = fwd_b_run;
               if (ex_branch_taken) begin
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
               end else if (hazard) begin
                  pc_en       = 1'b0;
                  if_id_en    = 1'b0;
                  id_ex_flush = 1'b1;
               end
            end
         end
         S_ERR: begin
            pc_en           = 1'b0;
            if_id_en        = 1'b0;
            id_ex_en        = 1'b0;
            ex_mem_en       = 1'b0;
            mem_wb_en       = 1'b0;
            mem_wb_flush    = 1'b1;
            mem_timeout_err = 1'b1;
         end
         default: state_nxt = S_RUN;
      endcase

      // Pipeline runs freely while held in reset.
      if (!rst) begin
         pc_en           = 1'b1;
         if_id_en        = 1'b1;
         id_ex_en        = 1'b1;
         ex_mem_en       = 1'b1;
         mem_wb_en       = 1'b1;
         if_id_flush     = 1'b0;
         id_ex_flush     = 1'b0;
         mem_wb_flush    = 1'b0;
         fwd_a           = 2'b00;
         fwd_b           = 2'b00;
         mem_timeout_err = 1'b0;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl; expectations are hand-computed per step.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_write_reg, mem_write_reg, wb_write_reg;
   logic       id_uses_rs, id_uses_rt, ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write;
   logic       ex_branch_taken, dmem_req, dmem_ready;
   logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic       if_id_flush, id_ex_flush, mem_wb_flush;
   logic [1:0] fwd_a, fwd_b;
   logic [5:0] stall_cnt;
   logic       mem_timeout_err;

   int checks = 0;
   int failures = 0;
   int exp_sc = 0;

   // {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id,id_ex,mem_wb flushes}
   localparam logic [7:0] C_RUN = 8'b11111_000;
   localparam logic [7:0] C_MEM = 8'b00001_001;
   localparam logic [7:0] C_ERR = 8'b00000_001;
   localparam logic [7:0] C_BR  = 8'b11111_110;
   localparam logic [7:0] C_HZ  = 8'b00111_010;

   logic [7:0] ctl;
   assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_wb_flush};

   pipe_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(6)) dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_write_reg(ex_write_reg), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .mem_write_reg(mem_write_reg), .mem_reg_write(mem_reg_write),
      .wb_write_reg(wb_write_reg), .wb_reg_write(wb_reg_write), .ex_branch_taken(ex_branch_taken),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .mem_timeout_err(mem_timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock edge; st says whether pc_en is low at that edge.
   task automatic cyc(input bit st);
      @(posedge clk);
      if (st && exp_sc < 63) exp_sc++;
      #1;
   endtask

   task automatic idle();
      id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
      ex_rs = 0; ex_rt = 0; ex_write_reg = 0; ex_reg_write = 0; ex_mem_read = 0;
      mem_write_reg = 0; mem_reg_write = 0; wb_write_reg = 0; wb_reg_write = 0;
      ex_branch_taken = 0; dmem_req = 0; dmem_ready = 0;
   endtask

   initial begin
      idle();
      rst = 1'b0;
      dmem_req = 1; ex_mem_read = 1; ex_reg_write = 1; ex_write_reg = 2;
      id_rs = 2; id_uses_rs = 1; mem_reg_write = 1; mem_write_reg = 3; ex_rs = 3;
      #2;
      chk("rst_ctl", 32'(ctl), 32'(C_RUN));
      chk("rst_fwd_a", 32'(fwd_a), 0);
      chk("rst_err", 32'(mem_timeout_err), 0);
      @(posedge clk); #1;
      chk("rst_ctl_edge", 32'(ctl), 32'(C_RUN));
      chk("rst_stall_cnt", 32'(stall_cnt), 0);
      @(negedge clk);
      rst = 1'b1;
      idle();
      #1;
      chk("idle_ctl", 32'(ctl), 32'(C_RUN));
      cyc(0);

`ifdef FWD_EN
      ex_mem_read = 1; ex_reg_write = 1; ex_write_reg = 2;
      id_rs = 2; id_rt = 4; id_uses_rs = 1; id_uses_rt = 1;
      #1; chk("lu_stall", 32'(ctl), 32'(C_HZ));
      cyc(1);
      idle(); id_rs = 2; id_rt = 4; id_uses_rs = 1; id_uses_rt = 1;
      mem_reg_write = 1; mem_write_reg = 2;
      #1; chk("lu_next_ctl", 32'(ctl), 32'(C_RUN));
      cyc(0);
      idle(); ex_rs = 2; ex_rt = 4; wb_reg_write = 1; wb_write_reg = 2;
      #1; chk("lu_fwd_a", 32'(fwd_a), 1);
      chk("lu_fwd_b", 32'(fwd_b), 0);
      cyc(0);
      idle(); ex_mem_read = 1; ex_reg_write = 1; ex_write_reg = 4;
      id_rs = 1; id_uses_rs = 1; id_rt = 4; id_uses_rt = 0;
      #1; chk("lu_rt_unused", 32'(ctl), 32'(C_RUN));
      id_uses_rt = 1;
      #1; chk("lu_rt_used", 32'(ctl), 32'(C_HZ));
      ex_write_reg = 0; id_rt = 0;
      #1; chk("lu_dest0", 32'(ctl), 32'(C_RUN));
      ex_write_reg = 4; id_rt = 4; ex_mem_read = 0;
      #1; chk("lu_not_load", 32'(ctl), 32'(C_RUN));
      idle(); mem_reg_write = 1; mem_write_reg = 5; wb_reg_write = 1; wb_write_reg = 5;
      ex_rs = 5; ex_rt = 5;
      #1; chk("fwd_mem_pri_a", 32'(fwd_a), 2);
      chk("fwd_mem_pri_b", 32'(fwd_b), 2);
      mem_reg_write = 0;
      #1; chk("fwd_wb_a", 32'(fwd_a), 1);
      wb_reg_write = 0;
      #1; chk("fwd_none_a", 32'(fwd_a), 0);
      mem_reg_write = 1; wb_reg_write = 1; mem_write_reg = 0; wb_write_reg = 0; ex_rs = 0; ex_rt = 0;
      #1; chk("fwd_r0_a", 32'(fwd_a), 0);
      chk("fwd_r0_b", 32'(fwd_b), 0);
      mem_write_reg = 5; wb_write_reg = 7; ex_rs = 5; ex_rt = 7;
      #1; chk("fwd_split_a", 32'(fwd_a), 2);
      chk("fwd_split_b", 32'(fwd_b), 1);
`else
      ex_reg_write = 1; ex_write_reg = 2;
      id_rs = 2; id_rt = 4; id_uses_rs = 1; id_uses_rt = 1;
      mem_reg_write = 1; mem_write_reg = 9; ex_rs = 9;
      #1; chk("raw_ex", 32'(ctl), 32'(C_HZ));
      chk("raw_fwd_a", 32'(fwd_a), 0);
      cyc(1);
      idle(); id_rs = 2; id_rt = 4; id_uses_rs = 1; id_uses_rt = 1;
      mem_reg_write = 1; mem_write_reg = 2;
      #1; chk("raw_mem", 32'(ctl), 32'(C_HZ));
      cyc(1);
      idle(); id_rs = 2; id_rt = 4; id_uses_rs = 1; id_uses_rt = 1;
      wb_reg_write = 1; wb_write_reg = 2; ex_rt = 2;
      #1; chk("raw_wb", 32'(ctl), 32'(C_RUN));
      chk("raw_fwd_b", 32'(fwd_b), 0);
      cyc(0);
      idle(); ex_reg_write = 1; ex_write_reg = 2; id_rs = 2; id_uses_rs = 0; id_rt = 4; id_uses_rt = 1;
      #1; chk("raw_rs_unused", 32'(ctl), 32'(C_RUN));
      idle(); ex_reg_write = 1; ex_write_reg = 0; id_rs = 0; id_uses_rs = 1;
      #1; chk("raw_dest0", 32'(ctl), 32'(C_RUN));
      idle(); ex_write_reg = 2; id_rs = 2; id_uses_rs = 1;
      #1; chk("raw_no_write", 32'(ctl), 32'(C_RUN));
      idle(); mem_write_reg = 4; id_rt = 4; id_uses_rt = 1;
      #1; chk("raw_mem_no_write", 32'(ctl), 32'(C_RUN));
      mem_reg_write = 1;
      #1; chk("raw_mem_rt", 32'(ctl), 32'(C_HZ));
`endif
      idle();
      #1; chk("hz_stall_cnt", 32'(stall_cnt), 32'(exp_sc));

      ex_mem_read = 1; ex_reg_write = 1; ex_write_reg = 2; id_rs = 2; id_uses_rs = 1;
      mem_reg_write = 1; mem_write_reg = 2; ex_branch_taken = 1;
      #1; chk("br_over_hz", 32'(ctl), 32'(C_BR));
      cyc(0);
      chk("br_stall_cnt", 32'(stall_cnt), 32'(exp_sc));
      dmem_req = 1;
      #1; chk("mem_over_br", 32'(ctl), 32'(C_MEM));

      idle(); dmem_req = 1; mem_reg_write = 1; mem_write_reg = 5; ex_rs = 5;
      #1; chk("mw_entry", 32'(ctl), 32'(C_MEM));
      chk("mw_entry_fwd", 32'(fwd_a), 0);
      cyc(1);
      chk("mw_1", 32'(ctl), 32'(C_MEM));
      chk("mw_1_fwd", 32'(fwd_a), 0);
      cyc(1);
      chk("mw_2", 32'(ctl), 32'(C_MEM));
      cyc(1);
      dmem_ready = 1;
      #1; chk("mw_done", 32'(ctl), 32'(C_RUN));
`ifdef FWD_EN
      chk("mw_done_fwd", 32'(fwd_a), 2);
`else
      chk("mw_done_fwd", 32'(fwd_a), 0);
`endif
      cyc(0);
      idle();
      #1; chk("mw_back_run", 32'(ctl), 32'(C_RUN));
      chk("mw_stall_cnt", 32'(stall_cnt), 32'(exp_sc));
      dmem_req = 1; dmem_ready = 1;
      #1; chk("mw_ready_now", 32'(ctl), 32'(C_RUN));
      cyc(0);

      idle(); dmem_req = 1;
      #1; chk("to_entry", 32'(ctl), 32'(C_MEM));
      for (int i = 0; i < 15; i++) cyc(1);
      chk("to_wait15_err", 32'(mem_timeout_err), 0);
      chk("to_wait15_ctl", 32'(ctl), 32'(C_MEM));
      cyc(1);
      chk("to_err", 32'(mem_timeout_err), 1);
      chk("to_err_ctl", 32'(ctl), 32'(C_ERR));
      dmem_req = 0; dmem_ready = 1;
      #1; chk("to_err_ready", 32'(ctl), 32'(C_ERR));
      cyc(1);
      cyc(1);
      chk("to_err_sticky", 32'(mem_timeout_err), 1);
      chk("to_stall_cnt", 32'(stall_cnt), 32'(exp_sc));
      #2 rst = 1'b0;
      #1;
      chk("to_rst_err", 32'(mem_timeout_err), 0);
      chk("to_rst_cnt", 32'(stall_cnt), 0);
      chk("to_rst_ctl", 32'(ctl), 32'(C_RUN));
      exp_sc = 0;
      @(negedge clk);
      rst = 1'b1;
      idle();
      #1; chk("post_rst_run", 32'(ctl), 32'(C_RUN));

      dmem_req = 1;
      for (int i = 0; i < 70; i++) cyc(1);
      chk("sat_err", 32'(mem_timeout_err), 1);
      chk("sat_cnt", 32'(stall_cnt), 32'(exp_sc));
      cyc(1);
      chk("sat_hold", 32'(stall_cnt), 63);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
